// File: rtl/bitwise_op_arbiter.sv
// Two-requester round-robin arbiter in front of one shared AND/OR unit.
// A request is captured in IDLE, evaluated in EXEC, and its result is held
// in DONE until the consumer takes it. Grants alternate under contention.
module bitwise_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic [15:0]      done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             ptr;
  logic             grant_id;
  logic             accept;
  logic             res_fire;
  logic             cap_op;
  logic             cap_id;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;

  // Grant selection: a lone requester wins, contention is settled by ptr
  always_comb begin
    grant_id   = (req0_valid && req1_valid) ? ptr : req1_valid;
    req0_ready = rst_n && (state == IDLE) && req0_valid && !grant_id;
    req1_ready = rst_n && (state == IDLE) && req1_valid && grant_id;
    accept     = req0_ready || req1_ready;
    res_fire   = res_valid && res_ready;
  end

  // Next-state logic for the IDLE -> EXEC -> DONE sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    if (res_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, round-robin pointer and captured request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      cap_op <= 1'b0;
      cap_id <= 1'b0;
      cap_a  <= '0;
      cap_b  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cap_op <= grant_id ? req1_op : req0_op;
        cap_a  <= grant_id ? req1_a  : req0_a;
        cap_b  <= grant_id ? req1_b  : req0_b;
        cap_id <= grant_id;
        ptr    <= !grant_id;
      end
    end
  end

  // Result registers and completion counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      done_cnt  <= 16'd0;
    end else begin
      if (state == EXEC) begin
        res_data  <= cap_op ? (cap_a & cap_b) : (cap_a | cap_b);
        res_id    <= cap_id;
        res_valid <= 1'b1;
      end else if (state == DONE && res_fire) begin
        res_valid <= 1'b0;
        done_cnt  <= done_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// Directed bench for bitwise_op_arbiter: a vector table of single and
// contended requests plus hand-written sequences for contention from reset,
// result backpressure, reset during an operation and counter wrap.
module tb_bitwise_op_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic       req0_ready;
  logic       req0_op;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic       req1_op;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_id;
  logic [15:0] done_cnt;

  typedef struct {
    logic       v0;
    logic       op0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       v1;
    logic       op1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       exp_id;
    logic [7:0] exp_data;
  } vec_t;

  vec_t        tbl[10];
  int          applied_cnt;
  int          miscompare_cnt;
  logic [15:0] exp_cnt;

  bitwise_op_arbiter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .done_cnt   (done_cnt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied_cnt++;
    if (act !== exp) begin
      miscompare_cnt++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One request/result transaction with res_ready high; starts and ends on a negedge in IDLE
  task automatic applyStimulus(input vec_t v, input string tag);
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
    #1;
    checkOutput({tag, " req0_ready"}, {31'd0, req0_ready}, {31'd0, v.v0 && !v.exp_id});
    checkOutput({tag, " req1_ready"}, {31'd0, req1_ready}, {31'd0, v.v1 && v.exp_id});
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    #1;
    checkOutput({tag, " exec res_valid"}, {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    checkOutput({tag, " res_valid"}, {31'd0, res_valid}, 32'd1);
    checkOutput({tag, " res_data"}, {24'd0, res_data}, {24'd0, v.exp_data});
    checkOutput({tag, " res_id"}, {31'd0, res_id}, {31'd0, v.exp_id});
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    checkOutput({tag, " res_valid cleared"}, {31'd0, res_valid}, 32'd0);
    checkOutput({tag, " done_cnt"}, {16'd0, done_cnt}, {16'd0, exp_cnt});
  endtask

  initial begin
    applied_cnt    = 0;
    miscompare_cnt = 0;
    exp_cnt        = 16'd0;

    //        v0  op0  a0     b0     v1  op1  a1     b1     id    data
    tbl[0] = '{1'b1, 1'b1, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h30};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA0, 8'h05, 1'b1, 8'hA5};
    tbl[2] = '{1'b1, 1'b1, 8'hFF, 8'h0F, 1'b1, 1'b0, 8'h11, 8'h22, 1'b0, 8'h0F};
    tbl[3] = '{1'b1, 1'b0, 8'h11, 8'h22, 1'b1, 1'b1, 8'hCC, 8'hAA, 1'b1, 8'h88};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF};
    tbl[6] = '{1'b1, 1'b1, 8'h5A, 8'hF0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h50};
    tbl[7] = '{1'b1, 1'b0, 8'h01, 8'h02, 1'b1, 1'b0, 8'h40, 8'h08, 1'b1, 8'h48};
    tbl[8] = '{1'b1, 1'b0, 8'h81, 8'h18, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h99};
    tbl[9] = '{1'b1, 1'b1, 8'h0F, 8'h0F, 1'b1, 1'b1, 8'h33, 8'h0F, 1'b1, 8'h03};

    // Reset with a pending request: ready must stay low, outputs zero
    rst_n = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_valid = 1'b0; req1_op = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("reset res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("reset res_data", {24'd0, res_data}, 32'd0);
    checkOutput("reset res_id", {31'd0, res_id}, 32'd0);
    checkOutput("reset done_cnt", {16'd0, done_cnt}, 32'd0);
    rst_n = 1'b1;

    // Contention from reset: grants must alternate 0,1,0,1
    req0_valid = 1'b1; req0_op = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = 8'hA0; req1_b = 8'h05;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("contend req0_ready", {31'd0, req0_ready}, {31'd0, (k % 2) == 0});
      checkOutput("contend req1_ready", {31'd0, req1_ready}, {31'd0, (k % 2) == 1});
      @(negedge clk);
      checkOutput("contend exec ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      @(negedge clk);
      checkOutput("contend res_valid", {31'd0, res_valid}, 32'd1);
      checkOutput("contend res_id", {31'd0, res_id}, {31'd0, (k % 2) == 1});
      checkOutput("contend res_data", {24'd0, res_data}, (k % 2) ? 32'hA5 : 32'h30);
      checkOutput("contend done ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      @(negedge clk);
      exp_cnt = exp_cnt + 16'd1;
      checkOutput("contend done_cnt", {16'd0, done_cnt}, {16'd0, exp_cnt});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles, no accepts meanwhile
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b1; req0_a = 8'h3C; req0_b = 8'h0F;
    #1;
    checkOutput("bp req0_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_a = 8'hFF; req0_b = 8'hFF;
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = 8'h01; req1_b = 8'h80;
    #1;
    checkOutput("bp exec ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp res_valid", {31'd0, res_valid}, 32'd1);
      checkOutput("bp res_data", {24'd0, res_data}, 32'h0C);
      checkOutput("bp res_id", {31'd0, res_id}, 32'd0);
      checkOutput("bp ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    checkOutput("bp res_valid cleared", {31'd0, res_valid}, 32'd0);
    checkOutput("bp done_cnt", {16'd0, done_cnt}, {16'd0, exp_cnt});
    checkOutput("bp next grant", {30'd0, req0_ready, req1_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp2 res_data", {24'd0, res_data}, 32'h81);
    checkOutput("bp2 res_id", {31'd0, res_id}, 32'd1);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    checkOutput("bp2 done_cnt", {16'd0, done_cnt}, {16'd0, exp_cnt});

    // Reset while in EXEC drops the operation
    req0_valid = 1'b1; req0_op = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = 8'h12; req1_b = 8'h34;
    #1;
    checkOutput("rst ready forced low", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(negedge clk);
    exp_cnt = 16'd0;
    checkOutput("rst res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst done_cnt", {16'd0, done_cnt}, 32'd0);
    checkOutput("rst res_data", {24'd0, res_data}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst grant req0", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("rst exec res_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    checkOutput("rst res_data after", {24'd0, res_data}, 32'hFF);
    checkOutput("rst res_id after", {31'd0, res_id}, 32'd0);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    checkOutput("rst done_cnt after", {16'd0, done_cnt}, {16'd0, exp_cnt});

    // Counter wrap: preload near the top, then complete two operations
    force dut.done_cnt = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.done_cnt;
    exp_cnt = 16'hFFFE;
    applyStimulus(tbl[8], "wrap0");
    applyStimulus(tbl[9], "wrap1");
    checkOutput("wrap final", {16'd0, done_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied_cnt, miscompare_cnt);
    $finish;
  end

endmodule

// File: doc/bitwise_op_arbiter.md
# bitwise_op_arbiter

Shares one AND/OR bitwise logic unit between two requesters. Each requester submits an operation (op select plus two operands) over a valid/ready handshake. The block arbitrates round-robin, sequences the shared unit through a small state machine, and returns a registered result tagged with the requester ID over a valid/ready handshake. It sits between the requester pipelines and the shared bitwise datapath and serialises access to it.

## Interface
- WIDTH, 8, operand/result width in bits
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle (when valid)
- req0_op  input  1  requester 0 op select: 1 = AND, 0 = OR
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as above for requester 1
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  WIDTH  a & b (op=1) or a | b (op=0)
- res_id  output  1  requester that issued the result
- done_cnt  output  16  count of completed result handshakes, wraps

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - Grant is combinational from the two valids and priority pointer `ptr` (reset 0).
  - Only req0 valid: grant 0. Only req1 valid: grant 1. Both valid: grant `ptr`.
  - req*_ready = 1 only for the granted requester, and only in IDLE; otherwise 0.
  - On a handshake, capture op, a, b and id, set `ptr` to the other requester (even if it was not contending), go to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - Compute the captured op on the captured operands.
  - Load res_data and res_id, set res_valid, go to DONE.
- DONE:
  - Hold res_valid, res_data and res_id stable until res_ready.
  - On res_valid & res_ready: clear res_valid, increment done_cnt (16-bit wrap, 0xFFFF -> 0x0000), go to IDLE.
- No new request is accepted in EXEC or DONE; requesters keep valid asserted and wait.
- Captured operands are registered. Requester inputs may change after their handshake without affecting the result.
- Requester inputs need not be stable before a handshake. Only values present in the handshake cycle matter.
- Reset (rst_n = 0 at a clock edge, any state):
  - Next state IDLE, ptr = 0.
  - res_valid = 0, res_data = 0, res_id = 0, done_cnt = 0.
  - Any in-flight operation is discarded without a result.
  - req*_ready is forced to 0 while rst_n is low.

## Timing
- Request handshake in cycle T (IDLE) -> EXEC in T+1 -> res_valid = 1 from T+2.
- res_ready already high at T+2: handshake at T+2, IDLE at T+3, next request accepted at T+3 at earliest.
- Peak throughput is one operation per 3 cycles. Backpressure on res_ready extends DONE indefinitely.
- req*_ready is combinational from req*_valid, state and ptr. There is no combinational path from res_ready to req*_ready.
- All other outputs are registered.
- Simultaneous valids in IDLE: exactly one ready asserted. Neither requester waits more than one other grant.
- Reset values: all outputs 0.

## Test plan
- Single request: req0 op=1, a=0xF0, b=0x3C, res_ready=1 -> req0_ready at T, res_valid at T+2 with res_data=0x30, res_id=0, done_cnt=1 at T+3.
- OR path: req1 op=0, a=0xA0, b=0x05 -> res_data=0xA5, res_id=1.
- Contention: both valid continuously from reset with distinct operands -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1; each request accepted exactly once per grant.
- Backpressure: res_ready held 0 for 5 cycles after res_valid -> res_valid/res_data/res_id stable all 5 cycles, both req*_ready = 0, no new accept until the cycle after the result handshake.
- Reset mid-operation: assert rst_n = 0 in EXEC -> next cycle state IDLE, res_valid = 0, done_cnt = 0, no result for the dropped request; after release, req1-then-req0 contention grants req0 first (ptr = 0).
- Counter wrap: force 65536 completions (or preload via a long loop) -> done_cnt goes 0xFFFF -> 0x0000.
